fp_addsub_sched: RTL
====================

# fp_addsub_sched

Round-robin scheduler that shares one fp_add_sub datapath among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the winning pair onto the datapath inputs. It tracks each issued operation through the datapath's fixed latency with a tag pipeline, then returns the sum/difference with the originating requester id. It sits between the requester cluster and the fp_add_sub instance at the arithmetic-unit top level.

## Interface
- NREQ, 4: number of requesters (2..8).
- FPU_LAT, 3: cycles from fpu_num1/fpu_num2 change to the matching fpu_s value.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hold  in  1  when high, no new grants; in-flight operations still drain.
- req_valid  in  NREQ  requester i has an operation pending.
- req_op  in  NREQ  per requester: 0 = add, 1 = subtract.
- req_a  in  NREQ×32  per requester operand A (IEEE-754 single).
- req_b  in  NREQ×32  per requester operand B.
- req_ready  out  NREQ  one-hot or zero; grant to requester i.
- fpu_num1  out  32  registered operand to datapath num1.
- fpu_num2  out  32  registered operand to datapath num2.
- fpu_s  in  32  datapath result S.
- res_valid  out  1  res_data/res_id valid this cycle; no backpressure.
- res_id  out  $clog2(NREQ)  originating requester.
- res_data  out  32  result, equal to fpu_s.
- in_flight  out  $clog2(FPU_LAT+2)  number of issued, not yet returned operations.
- idle  out  1  high when in_flight == 0 and no grant this cycle.

## Operation
- Arbitration is combinational from registered pointer last_gnt: scan requesters last_gnt+1, last_gnt+2, … (mod NREQ). The first one with req_valid set gets req_ready. When hold is high, req_ready is zero.
- Transfer = req_valid[i] & req_ready[i]. On a transfer, fpu_num1 <= req_a[i]. fpu_num2 <= req_b[i] with bit 31 inverted when req_op[i] = 1. The tag pipeline stage 0 is loaded with {v=1, id=i}, and last_gnt <= i.
- With no transfer, fpu_num1/fpu_num2 hold their values and stage 0 is loaded with v=0.
- The tag pipeline is FPU_LAT+1 stages and shifts every cycle. res_valid/res_id are the last stage. res_data = fpu_s, combinational.
- One issue per cycle maximum. Throughput is 1 operation/cycle; no stalls, because the datapath has no enable.
- in_flight counts valid tags. It is incremented on transfer and decremented when res_valid; on the same cycle it is unchanged.
- Requesters must hold req_valid and operands stable until ready. A requester may drop valid without transfer.
- No special handling of NaN/Inf/zero; the sign flip is applied unconditionally.

## Timing
- Reset values: last_gnt = NREQ-1 (requester 0 has first priority), all tag valid bits 0, fpu_num1 = fpu_num2 = 0, res_valid = 0, res_id = 0, in_flight = 0, idle = 1, req_ready = 0 while rst is asserted.
- Latency: a transfer in cycle t gives res_valid in cycle t+1+FPU_LAT, i.e. 4 cycles with defaults.
- Results return in issue order.
- Reset mid-operation: all tags are cleared; in-flight results are discarded and never signalled. The datapath's own reset is driven separately at top level.
- hold rising in the same cycle as a pending request: no grant that cycle. hold has no effect on the tag pipeline.
- Single requester valid continuously: it is granted every cycle.

## Structure
- Package fp_sched_pkg holds:
  - defaults NREQ_DEF and FPU_LAT_DEF;
  - typedef struct packed {logic v; logic [IDW-1:0] id;} fp_tag_t;
  - localparam SIGN_BIT = 31.
- Sub-module rr_arbiter (parameter N): inputs req, last_gnt, en; outputs one-hot gnt and encoded gnt_id. It is purely combinational.
- The tag pipeline, operand registers, pointer and counter live in fp_addsub_sched.

## Test plan
- Reset, then requester 0 issues a=0x3F800000 (1.0), b=0x40000000 (2.0), add. Required: transfer in cycle t; res_valid in t+4 with res_id=0, res_data=0x40400000; in_flight rises 0→1 then falls to 0.
- Requester 2 subtracts: a=0x40400000, b=0x3F800000, op=1. Required: fpu_num2 = 0xBF800000; result 0x40000000, res_id=2.
- All four requesters hold valid for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; 8 results in the same order, back-to-back, with in_flight peaking at 4.
- hold=1 with requests pending. Required: req_ready=0 throughout; existing tags drain; idle=1 once drained. Releasing hold resumes the rotation from last_gnt+1.
- Assert rst while 3 operations are in flight. Required: no res_valid afterward, in_flight=0, and the next grant goes to requester 0.
- Requester 1 drops req_valid before being granted while requester 3 is valid. Required: requester 3 is granted, and no result is ever returned for requester 1.

Source files
------------

// File: rtl/fp_addsub_sched_pkg.sv
// fp_sched_pkg: shared defaults and types for the fp_add_sub scheduler slice.
//   NREQ_DEF / FPU_LAT_DEF : default requester count and datapath latency
//   TAG_IDW                : tag id width, sized for the largest legal NREQ (8)
//   fp_tag_t               : one tag-pipeline stage {valid, requester id}
//   SIGN_BIT               : IEEE-754 single sign position, flipped for subtract
package fp_sched_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned FPU_LAT_DEF = 3;
  localparam int unsigned TAG_IDW     = 3;
  localparam int unsigned SIGN_BIT    = 31;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } fp_tag_t;

endpackage

// File: rtl/fp_addsub_sched_if.sv
// fp_addsub_sched_if: requester-side bundle of the scheduler.
//   req_valid/req_op/req_a/req_b : per-requester operation offer
//   req_ready                    : one-hot (or zero) grant
//   res_valid/res_id/res_data    : returned result, no backpressure
// master = requester cluster, slave = scheduler.
interface fp_addsub_sched_if
  import fp_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_op;
  logic [NREQ-1:0][31:0] req_a;
  logic [NREQ-1:0][31:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [31:0]           res_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, res_valid, res_id, res_data
  );
endinterface

// File: rtl/fp_addsub_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req      : request vector
//   last_gnt : index granted most recently (scan starts one above it)
//   en       : grant enable; gnt is zero when low
//   gnt      : one-hot grant
//   gnt_id   : encoded index of gnt (0 when no grant)
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_gnt,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);
  localparam int unsigned W = $clog2(N);

  logic [W-1:0] idx;
  logic         found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = W'((32'(last_gnt) + k) % N);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_id     = idx;
      end
    end
  end
endmodule

// File: rtl/fp_addsub_sched.sv
// fp_addsub_sched: shares one fixed-latency fp_add_sub datapath among NREQ
// requesters with round-robin arbitration and a tag pipeline for result return.
//   clk, rst  : clock, asynchronous active-high reset
//   hold      : suppress new grants; in-flight operations still drain
//   bus       : requester handshakes and result return (slave modport)
//   fpu_num1  : registered operand A to the datapath
//   fpu_num2  : registered operand B, sign inverted for subtract
//   fpu_s     : datapath result, forwarded as bus.res_data
//   in_flight : issued but not yet returned operations
//   idle      : no operation in flight and no grant this cycle
module fp_addsub_sched
  import fp_sched_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned FPU_LAT = FPU_LAT_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           hold,
  fp_addsub_sched_if.slave               bus,
  output logic [31:0]                    fpu_num1,
  output logic [31:0]                    fpu_num2,
  input  logic [31:0]                    fpu_s,
  output logic [$clog2(FPU_LAT+2)-1:0]   in_flight,
  output logic                           idle
);
  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CW   = $clog2(FPU_LAT + 2);
  localparam int unsigned NSTG = FPU_LAT + 1;

  logic [IDW-1:0]  last_gnt;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  fp_tag_t         tag_in;
  fp_tag_t         tags [NSTG];

  // Grants are also blocked during reset so req_ready reads zero throughout.
  rr_arbiter #(.N(NREQ)) u_arb (
    .req      (bus.req_valid),
    .last_gnt (last_gnt),
    .en       (!hold && !rst),
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  assign bus.req_ready = gnt;
  assign xfer          = |(bus.req_valid & gnt);

  always_comb begin
    tag_in    = '0;
    tag_in.v  = xfer;
    tag_in.id = TAG_IDW'(gnt_id);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= IDW'(NREQ - 1);
      fpu_num1  <= '0;
      fpu_num2  <= '0;
      in_flight <= '0;
      for (int unsigned s = 0; s < NSTG; s++) tags[s] <= '0;
    end else begin
      tags[0] <= tag_in;
      for (int unsigned s = 1; s < NSTG; s++) tags[s] <= tags[s-1];
      if (xfer) begin
        fpu_num1 <= bus.req_a[gnt_id];
        fpu_num2 <= bus.req_b[gnt_id] ^ (32'(bus.req_op[gnt_id]) << SIGN_BIT);
        last_gnt <= gnt_id;
      end
      case ({xfer, bus.res_valid})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign bus.res_valid = tags[NSTG-1].v;
  assign bus.res_id    = tags[NSTG-1].id[IDW-1:0];
  assign bus.res_data  = fpu_s;
  assign idle          = (in_flight == '0) && !xfer;
endmodule
